// File: rtl/core_inst_seq.sv
// Instruction sequencer for core: drives a full 3x3 convolution pass, one kernel
// position per loop, then the PMEM accumulation pass one output pixel at a time.
module core_inst_seq #(
    parameter int          col      = 8,
    parameter int          len_kij  = 9,
    parameter int          len_nij  = 4,
    parameter int          len_onij = 4,
    parameter logic [10:0] act_base = 11'd0,
    parameter logic [10:0] wgt_base = 11'b10000000000,
    parameter int          gap_len  = 11,
    localparam int         OW       = (len_onij > 1) ? $clog2(len_onij) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ofifo_valid,
    input  logic [10:0]   acc_addr,
    output logic [OW-1:0] acc_o,
    output logic [3:0]    acc_j,
    output logic [33:0]   inst,
    output logic          out_valid,
    output logic          busy,
    output logic          done
);

    // state     | meaning
    // S_IDLE    | waiting for start, NOP
    // S_W_L0    | weight rows XMEM -> L0
    // S_W_LOAD  | L0 -> PE weight load
    // S_GAP     | idle cycles before activation fetch
    // S_A_L0    | activation words XMEM -> L0
    // S_EXEC    | L0 -> PE execute
    // S_DRAIN   | wait for OFIFO to hold a full row
    // S_OF_WR   | OFIFO -> PMEM partial sums
    // S_NEXT_K  | advance kij or leave the kernel loop
    // S_ACC_RD  | read all kij slots of one output pixel
    // S_ACC_OUT | accumulated pixel valid at sfp_out
    typedef enum logic [3:0] {
        S_IDLE, S_W_L0, S_W_LOAD, S_GAP, S_A_L0, S_EXEC,
        S_DRAIN, S_OF_WR, S_NEXT_K, S_ACC_RD, S_ACC_OUT
    } state_t;

    localparam logic [7:0]    T_COL_LAST  = 8'(col - 1);
    localparam logic [7:0]    T_GAP_LAST  = 8'(gap_len - 1);
    localparam logic [7:0]    T_NIJ_LAST  = 8'(len_nij - 1);
    localparam logic [7:0]    T_ONIJ_LAST = 8'(len_onij - 1);
    localparam logic [7:0]    T_KIJ       = 8'(len_kij);
    localparam logic [3:0]    KIJ_LAST    = 4'(len_kij - 1);
    localparam logic [OW-1:0] ONIJ_LAST   = OW'(len_onij - 1);
    localparam logic [10:0]   COL11       = 11'(col);

    state_t        state, state_d;
    logic [7:0]    t, t_d;
    logic [3:0]    kij, kij_d;
    logic [10:0]   pptr, pptr_d;
    logic [OW-1:0] acc_o_d;
    logic [33:0]   inst_d;

    logic        i_acc, i_cenp, i_wenp, i_cenx, i_wenx;
    logic        i_ofrd, i_l0rd, i_l0wr, i_ex, i_ld;
    logic [10:0] i_ap, i_ax;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            t         <= '0;
            kij       <= '0;
            pptr      <= '0;
            acc_o     <= '0;
            inst      <= {1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 11'd0, 7'd0};
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            t         <= t_d;
            kij       <= kij_d;
            pptr      <= pptr_d;
            acc_o     <= acc_o_d;
            inst      <= inst_d;
            out_valid <= (state_d == S_ACC_OUT);
            busy      <= (state_d != S_IDLE);
            done      <= (state == S_ACC_OUT) && (acc_o == ONIJ_LAST);
        end
    end

    assign acc_j = t[3:0];

    always_comb begin
        state_d = state;
        t_d     = t + 8'd1;
        kij_d   = kij;
        pptr_d  = pptr;
        acc_o_d = acc_o;
        case (state)
            S_IDLE: begin
                t_d = '0;
                if (start) begin
                    state_d = S_W_L0;
                    kij_d   = '0;
                    pptr_d  = '0;
                    acc_o_d = '0;
                end
            end
            S_W_L0:   if (t == T_COL_LAST) state_d = S_W_LOAD;
            S_W_LOAD: if (t == T_COL_LAST) state_d = S_GAP;
            S_GAP:    if (t == T_GAP_LAST) state_d = S_A_L0;
            S_A_L0:   if (t == T_NIJ_LAST) state_d = S_EXEC;
            S_EXEC:   if (t == T_NIJ_LAST) state_d = S_DRAIN;
            S_DRAIN:  if (ofifo_valid) state_d = S_OF_WR;
            S_OF_WR: begin
                pptr_d = pptr + 11'd1;
                if (t == T_ONIJ_LAST) state_d = S_NEXT_K;
            end
            S_NEXT_K: begin
                if (kij < KIJ_LAST) begin
                    kij_d   = kij + 4'd1;
                    state_d = S_W_L0;
                end else begin
                    state_d = S_ACC_RD;
                end
            end
            S_ACC_RD: if (t == T_KIJ) state_d = S_ACC_OUT;
            S_ACC_OUT: begin
                if (acc_o < ONIJ_LAST) begin
                    acc_o_d = acc_o + OW'(1);
                    state_d = S_ACC_RD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // every transition is a state entry, so the phase counter restarts
        if (state_d != state) t_d = '0;
    end

    always_comb begin
        i_acc  = 1'b0;
        i_cenp = 1'b1;
        i_wenp = 1'b1;
        i_ap   = '0;
        i_cenx = 1'b1;
        i_wenx = 1'b1;
        i_ax   = '0;
        i_ofrd = 1'b0;
        i_l0rd = 1'b0;
        i_l0wr = 1'b0;
        i_ex   = 1'b0;
        i_ld   = 1'b0;
        case (state)
            S_W_L0: begin
                i_cenx = 1'b0;
                i_l0wr = 1'b1;
                i_ax   = wgt_base + {7'd0, kij} * COL11 + {3'd0, t};
            end
            S_W_LOAD: begin
                i_l0rd = 1'b1;
                i_ld   = 1'b1;
            end
            S_A_L0: begin
                i_cenx = 1'b0;
                i_l0wr = 1'b1;
                i_ax   = act_base + {3'd0, t};
            end
            S_EXEC: begin
                i_l0rd = 1'b1;
                i_ex   = 1'b1;
            end
            S_OF_WR: begin
                i_ofrd = 1'b1;
                i_cenp = 1'b0;
                i_wenp = 1'b0;
                i_ap   = pptr;
            end
            S_ACC_RD: begin
                // acc trails the reads by one cycle to cover PMEM read latency
                i_acc = (t != 8'd0);
                if (t < T_KIJ) begin
                    i_cenp = 1'b0;
                    i_ap   = acc_addr;
                end
            end
            default: ;
        endcase
        inst_d = {i_acc, i_cenp, i_wenp, i_ap, i_cenx, i_wenx, i_ax,
                  i_ofrd, 1'b0, 1'b0, i_l0rd, i_l0wr, i_ex, i_ld};
    end

endmodule

// File: tb/tb_core_inst_seq.sv
// Bench for core_inst_seq: directed cycle-indexed expectations for a full pass,
// plus hand sequences for DRAIN stall, ignored start, async reset and restart.
module tb_core_inst_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [10:0] acc_addr;
    logic [1:0]  acc_o;
    logic [3:0]  acc_j;
    logic [33:0] inst;
    logic        out_valid;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic mon_en = 1'b0;
    int   n_acc = 0, n_rd = 0, n_wr = 0, n_ov = 0, n_done = 0;

    core_inst_seq dut (
        .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
        .acc_addr(acc_addr), .acc_o(acc_o), .acc_j(acc_j), .inst(inst),
        .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // external PMEM address lookup: slot j of pixel o lives at o*9+j
    assign acc_addr = 11'(acc_o) * 11'd9 + 11'(acc_j);

    always @(negedge clk) begin
        if (mon_en) begin
            if (inst[33]) n_acc++;
            if (!inst[32] && inst[31]) n_rd++;
            if (!inst[32] && !inst[31]) n_wr++;
            if (out_valid) n_ov++;
            if (done) n_done++;
        end
    end

    function automatic logic [33:0] mk(input logic acc, cenp, wenp, input logic [10:0] ap,
                                       input logic cenx, wenx, input logic [10:0] ax,
                                       input logic ofrd, l0rd, l0wr, ex, ld);
        return {acc, cenp, wenp, ap, cenx, wenx, ax, ofrd, 2'b00, l0rd, l0wr, ex, ld};
    endfunction

    function automatic logic [33:0] i_nop();
        return mk(0, 1, 1, 11'd0, 1, 1, 11'd0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [33:0] i_xl0(input logic [10:0] a);
        return mk(0, 1, 1, 11'd0, 0, 1, a, 0, 0, 1, 0, 0);
    endfunction
    function automatic logic [33:0] i_load();
        return mk(0, 1, 1, 11'd0, 1, 1, 11'd0, 0, 1, 0, 0, 1);
    endfunction
    function automatic logic [33:0] i_exec();
        return mk(0, 1, 1, 11'd0, 1, 1, 11'd0, 0, 1, 0, 1, 0);
    endfunction
    function automatic logic [33:0] i_ofwr(input logic [10:0] p);
        return mk(0, 0, 0, p, 1, 1, 11'd0, 1, 0, 0, 0, 0);
    endfunction
    function automatic logic [33:0] i_rd(input logic [10:0] a, input logic acc);
        return mk(acc, 0, 1, a, 1, 1, 11'd0, 0, 0, 0, 0, 0);
    endfunction

    typedef struct {
        int          cyc;
        logic [33:0] inst;
        logic        busy;
        logic        ov;
        logic        done;
        logic        chk_acc;
        logic [1:0]  acc_o;
        logic [3:0]  acc_j;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int c, input logic [33:0] i, input logic b, ov, d,
                       input logic ca = 1'b0, input logic [1:0] ao = 2'd0, input logic [3:0] aj = 4'd0);
        vec_t v;
        v.cyc = c; v.inst = i; v.busy = b; v.ov = ov; v.done = d;
        v.chk_acc = ca; v.acc_o = ao; v.acc_j = aj;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        ofifo_valid = 1'b0;
        #23;
        chk("rst_inst", inst, i_nop());
        chk("rst_busy", 34'(busy), 34'(0));
        chk("rst_ov", 34'(out_valid), 34'(0));
        chk("rst_done", 34'(done), 34'(0));
        @(negedge clk);
        reset = 1'b1;

        // pass A: DRAIN stall, start during EXEC, async reset mid OF_WR
        pulse_start();
        chk("a_busy0", 34'(busy), 34'(1));
        tick_to(1);  chk("a_wl0_first", inst, i_xl0(11'h400));
        tick_to(8);  chk("a_wl0_last", inst, i_xl0(11'h407));
        for (int k = 36; k <= 55; k++) begin
            tick_to(k);
            chk("a_drain_nop", inst, i_nop());
        end
        ofifo_valid = 1'b1;
        tick_to(56); chk("a_drain_end", inst, i_nop());
        for (int k = 0; k < 4; k++) begin
            tick_to(57 + k);
            chk("a_ofwr_k0", inst, i_ofwr(11'(k)));
        end
        for (int k = 0; k < 4; k++) begin
            tick_to(98 + k);
            chk("a_ofwr_k1", inst, i_ofwr(11'(4 + k)));
        end
        tick_to(175); start = 1'b1;
        tick_to(176); start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick_to(180 + k);
            chk("a_ofwr_k3", inst, i_ofwr(11'(12 + k)));
        end
        tick_to(185); chk("a_wl0_k4", inst, i_xl0(11'h420));
        tick_to(221); chk("a_ofwr_k4_0", inst, i_ofwr(11'd16));
        tick_to(222); chk("a_ofwr_k4_1", inst, i_ofwr(11'd17));
        #2 reset = 1'b0;
        #1;
        chk("async_rst_inst", inst, i_nop());
        chk("async_rst_busy", 34'(busy), 34'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("post_rst_done", 34'(done), 34'(0));

        // pass B: full pass with ofifo_valid tied high
        add(0,   i_nop(),            1, 0, 0);
        add(1,   i_xl0(11'h400),     1, 0, 0);
        add(8,   i_xl0(11'h407),     1, 0, 0);
        add(9,   i_load(),           1, 0, 0);
        add(16,  i_load(),           1, 0, 0);
        add(17,  i_nop(),            1, 0, 0);
        add(28,  i_xl0(11'd0),       1, 0, 0);
        add(31,  i_xl0(11'd3),       1, 0, 0);
        add(32,  i_exec(),           1, 0, 0);
        add(35,  i_exec(),           1, 0, 0);
        add(36,  i_nop(),            1, 0, 0);
        add(37,  i_ofwr(11'd0),      1, 0, 0);
        add(40,  i_ofwr(11'd3),      1, 0, 0);
        add(41,  i_nop(),            1, 0, 0);
        add(42,  i_xl0(11'h408),     1, 0, 0);
        add(365, i_ofwr(11'd32),     1, 0, 0);
        add(368, i_ofwr(11'd35),     1, 0, 0);
        add(370, i_rd(11'd0, 0),     1, 0, 0, 1, 2'd0, 4'd1);
        add(371, i_rd(11'd1, 1),     1, 0, 0, 1, 2'd0, 4'd2);
        add(378, i_rd(11'd8, 1),     1, 0, 0, 1, 2'd0, 4'd9);
        add(379, mk(1, 1, 1, 11'd0, 1, 1, 11'd0, 0, 0, 0, 0, 0), 1, 1, 0, 1, 2'd0, 4'd0);
        add(380, i_nop(),            1, 0, 0, 1, 2'd1, 4'd0);
        add(381, i_rd(11'd9, 0),     1, 0, 0, 1, 2'd1, 4'd1);
        add(390, mk(1, 1, 1, 11'd0, 1, 1, 11'd0, 0, 0, 0, 0, 0), 1, 1, 0, 1, 2'd1, 4'd0);
        add(401, mk(1, 1, 1, 11'd0, 1, 1, 11'd0, 0, 0, 0, 0, 0), 1, 1, 0, 1, 2'd2, 4'd0);
        add(403, i_rd(11'd27, 0),    1, 0, 0, 1, 2'd3, 4'd1);
        add(412, mk(1, 1, 1, 11'd0, 1, 1, 11'd0, 0, 0, 0, 0, 0), 1, 1, 0, 1, 2'd3, 4'd0);
        add(413, i_nop(),            0, 0, 1);

        ofifo_valid = 1'b1;
        mon_en = 1'b1;
        pulse_start();
        foreach (tbl[i]) begin
            tick_to(tbl[i].cyc);
            chk("b_inst", inst, tbl[i].inst);
            chk("b_busy", 34'(busy), 34'(tbl[i].busy));
            chk("b_out_valid", 34'(out_valid), 34'(tbl[i].ov));
            chk("b_done", 34'(done), 34'(tbl[i].done));
            if (tbl[i].chk_acc) begin
                chk("b_acc_o", 34'(acc_o), 34'(tbl[i].acc_o));
                chk("b_acc_j", 34'(acc_j), 34'(tbl[i].acc_j));
            end
        end

        // pass C: start in the cycle done is high, new pass from a clean slate
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        mon_en = 1'b0;
        chk("b_n_acc", 34'(n_acc), 34'(36));
        chk("b_n_rd", 34'(n_rd), 34'(36));
        chk("b_n_wr", 34'(n_wr), 34'(36));
        chk("b_n_out_valid", 34'(n_ov), 34'(4));
        chk("b_n_done", 34'(n_done), 34'(1));
        chk("c_busy", 34'(busy), 34'(1));
        chk("c_acc_o", 34'(acc_o), 34'(0));
        chk("c_done_low", 34'(done), 34'(0));
        tick_to(1);  chk("c_wl0_first", inst, i_xl0(11'h400));
        tick_to(37); chk("c_ofwr_first", inst, i_ofwr(11'd0));
        tick_to(40); chk("c_ofwr_last", inst, i_ofwr(11'd3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
